railway_crossing_system: RTL and testbench

//  Top-level controller for four independent level crossings sharing one clock.

---
 rtl/railway_crossing_system.sv | 210 +++++++++++++++++++++
 tb/tb_railway_crossing_system.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/railway_crossing_system.sv
// Four-crossing level-crossing controller: 2-of-3 sensor vote per crossing, per-crossing barrier/lamp
// FSM with weather-scaled timing, global emergency override, and a fault-driven efficiency score.
module railway_crossing_system #(
   parameter int WARN_CYCLES   = 20,
   parameter int CLEAR_CYCLES  = 100,
   parameter int OPEN_CYCLES   = 20,
   parameter int DISAGREE_CYC  = 16,
   parameter int FAULT_PENALTY = 5
) (
   input  logic        clk_50mhz,
   input  logic        rst_n,
   input  logic [3:0]  ir_sensor,
   input  logic [3:0]  vib_sensor,
   input  logic [3:0]  rfid_valid,
   input  logic        emergency_global,
   input  logic [1:0]  weather_mode,
   output logic [3:0]  barrier_down,
   output logic [3:0]  red_light,
   output logic [3:0]  yellow_light,
   output logic [3:0]  alarm_sound,
   output logic [7:0]  debug_led,
   output logic [7:0]  efficiency_score_out,
   output logic [11:0] crossing_states_out
);
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WARN    = 3'd1,
      ST_CLOSED  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_OPENING = 3'd4,
      ST_EMERG   = 3'd5
   } state_t;

   localparam logic [9:0] WARN_LD   = 10'(WARN_CYCLES - 1);
   localparam logic [9:0] WARN2_LD  = 10'(2 * WARN_CYCLES - 1);
   localparam logic [9:0] CLEAR_LD  = 10'(CLEAR_CYCLES - 1);
   localparam logic [9:0] CLEAR2_LD = 10'(2 * CLEAR_CYCLES - 1);
   localparam logic [9:0] OPEN_LD   = 10'(OPEN_CYCLES - 1);
   localparam logic [4:0] DIS_LAST  = 5'(DISAGREE_CYC - 1);
   localparam logic [4:0] DIS_CAP   = 5'(DISAGREE_CYC);

   logic [1:0]  rst_sync_q;
   logic        rst_int_n;
   logic [14:0] sync1_q, sync2_q;
   logic [3:0]  ir_s, vib_s, rfid_s, vote;
   logic        emerg_s;
   logic [1:0]  weather_s;
   logic [11:0] sens_all;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   always_ff @(posedge clk_50mhz or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {weather_mode, emergency_global, rfid_valid, vib_sensor, ir_sensor};
         sync2_q <= sync1_q;
      end
   end

   assign ir_s      = sync2_q[3:0];
   assign vib_s     = sync2_q[7:4];
   assign rfid_s    = sync2_q[11:8];
   assign emerg_s   = sync2_q[12];
   assign weather_s = sync2_q[14:13];
   assign sens_all  = sync2_q[11:0];
   assign vote      = (ir_s & vib_s) | (ir_s & rfid_s) | (vib_s & rfid_s);

   state_t      state_q [4];
   state_t      state_d [4];
   logic [9:0]  timer_q [4];
   logic [9:0]  timer_d [4];
   logic [9:0]  warn_ld, clear_ld;
   logic [3:0]  barrier_d, red_d, yellow_d, alarm_d;
   logic [3:0]  barrier_q, red_q, yellow_q, alarm_q;
   logic [11:0] states_d, states_q;

   assign warn_ld  = weather_s[1] ? WARN2_LD : WARN_LD;
   assign clear_ld = (weather_s != 2'b00) ? CLEAR2_LD : CLEAR_LD;

   always_comb begin
      barrier_d = '0;
      red_d     = '0;
      yellow_d  = '0;
      alarm_d   = '0;
      states_d  = '0;
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         timer_d[i] = (timer_q[i] != 10'd0) ? timer_q[i] - 10'd1 : 10'd0;
         if (emerg_s) begin
            state_d[i] = ST_EMERG;
         end else begin
            case (state_q[i])
               ST_IDLE: if (vote[i]) begin
                  state_d[i] = ST_WARN;
                  timer_d[i] = warn_ld;
               end
               ST_WARN: if (timer_q[i] == 10'd0) state_d[i] = ST_CLOSED;
               ST_CLOSED: if (!vote[i]) begin
                  state_d[i] = ST_HOLD;
                  timer_d[i] = clear_ld;
               end
               ST_HOLD: if (vote[i]) begin
                  state_d[i] = ST_CLOSED;
               end else if (timer_q[i] == 10'd0) begin
                  state_d[i] = ST_OPENING;
                  timer_d[i] = OPEN_LD;
               end
               ST_OPENING: if (vote[i]) state_d[i] = ST_CLOSED;
                           else if (timer_q[i] == 10'd0) state_d[i] = ST_IDLE;
               ST_EMERG: begin
                  state_d[i] = ST_HOLD;
                  timer_d[i] = clear_ld;
               end
               default: state_d[i] = ST_EMERG;
            endcase
         end
         // Lamps are decoded from the next state so they change on the same edge as the state.
         case (state_d[i])
            ST_WARN:    begin red_d[i] = 1'b1; yellow_d[i] = 1'b1; alarm_d[i] = 1'b1; end
            ST_CLOSED:  begin barrier_d[i] = 1'b1; red_d[i] = 1'b1; alarm_d[i] = 1'b1; end
            ST_HOLD:    begin barrier_d[i] = 1'b1; red_d[i] = 1'b1; end
            ST_OPENING: yellow_d[i] = 1'b1;
            ST_EMERG:   begin barrier_d[i] = 1'b1; red_d[i] = 1'b1; yellow_d[i] = 1'b1; alarm_d[i] = 1'b1; end
            default:    ;
         endcase
         states_d[3*i +: 3] = state_d[i];
      end
   end

   logic [4:0]  run_q [12];
   logic [4:0]  run_d [12];
   logic [11:0] logged_q, logged_d;
   logic [3:0]  fault_hits;
   logic [8:0]  fault_sum;
   logic [7:0]  fault_cnt_q, fault_cnt_d;
   logic [10:0] penalty;
   logic [7:0]  score_d, score_q;
   logic [7:0]  debug_d, debug_q;

   // Slot j watches sensor j/4 of crossing j%4; a slot fires once per occupancy.
   always_comb begin
      fault_hits = '0;
      for (int j = 0; j < 12; j++) begin
         run_d[j]    = '0;
         logged_d[j] = logged_q[j] & vote[j[1:0]];
         if (vote[j[1:0]] && !sens_all[j]) begin
            run_d[j] = (run_q[j] == DIS_CAP) ? run_q[j] : run_q[j] + 5'd1;
            if (run_q[j] == DIS_LAST && !logged_q[j]) begin
               logged_d[j] = 1'b1;
               fault_hits  = fault_hits + 4'd1;
            end
         end
      end
      fault_sum   = {1'b0, fault_cnt_q} + {5'b0, fault_hits};
      fault_cnt_d = fault_sum[8] ? 8'hFF : fault_sum[7:0];
      penalty     = 11'(fault_cnt_d) * 11'(FAULT_PENALTY);
      score_d     = (penalty >= 11'd100) ? 8'd0 : 8'(11'd100 - penalty);
      debug_d     = {(fault_cnt_d != 8'd0), emerg_s, weather_s, vote};
   end

   always_ff @(posedge clk_50mhz or negedge rst_int_n) begin
      if (!rst_int_n) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= ST_IDLE;
            timer_q[i] <= '0;
         end
         for (int j = 0; j < 12; j++) run_q[j] <= '0;
         logged_q    <= '0;
         fault_cnt_q <= '0;
         score_q     <= 8'd100;
         debug_q     <= '0;
         barrier_q   <= '0;
         red_q       <= '0;
         yellow_q    <= '0;
         alarm_q     <= '0;
         states_q    <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            timer_q[i] <= timer_d[i];
         end
         for (int j = 0; j < 12; j++) run_q[j] <= run_d[j];
         logged_q    <= logged_d;
         fault_cnt_q <= fault_cnt_d;
         score_q     <= score_d;
         debug_q     <= debug_d;
         barrier_q   <= barrier_d;
         red_q       <= red_d;
         yellow_q    <= yellow_d;
         alarm_q     <= alarm_d;
         states_q    <= states_d;
      end
   end

   assign barrier_down         = barrier_q;
   assign red_light            = red_q;
   assign yellow_light         = yellow_q;
   assign alarm_sound          = alarm_q;
   assign debug_led            = debug_q;
   assign efficiency_score_out = score_q;
   assign crossing_states_out  = states_q;

endmodule

// File: tb/tb_railway_crossing_system.sv
// Bench for railway_crossing_system: directed scenarios with literal checkpoints, then randomized
// traffic, all compared every cycle against a time-in-state behavioural model.
module tb_railway_crossing_system;
   logic        clk_50mhz = 1'b0;
   logic        rst_n;
   logic [3:0]  ir_sensor, vib_sensor, rfid_valid;
   logic        emergency_global;
   logic [1:0]  weather_mode;
   logic [3:0]  barrier_down, red_light, yellow_light, alarm_sound;
   logic [7:0]  debug_led, efficiency_score_out;
   logic [11:0] crossing_states_out;

   always #10 clk_50mhz = ~clk_50mhz;

   railway_crossing_system dut (
      .clk_50mhz(clk_50mhz), .rst_n(rst_n),
      .ir_sensor(ir_sensor), .vib_sensor(vib_sensor), .rfid_valid(rfid_valid),
      .emergency_global(emergency_global), .weather_mode(weather_mode),
      .barrier_down(barrier_down), .red_light(red_light), .yellow_light(yellow_light),
      .alarm_sound(alarm_sound), .debug_led(debug_led),
      .efficiency_score_out(efficiency_score_out), .crossing_states_out(crossing_states_out)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: state per crossing, cycles spent in it, and the duration fixed when it was entered.
   int          m_state   [4];
   int          m_elapsed [4];
   int          m_dur     [4];
   int          m_run     [4][3];
   bit          m_logged  [4][3];
   int          m_faults;
   logic [3:0]  m_vote;
   logic        m_emerg;
   logic [1:0]  m_weather;
   bit          m_active = 1'b0;
   logic [14:0] h1, h2, h3;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // {barrier, red, yellow, alarm} for each state code
   function automatic logic [3:0] lamps(input int s);
      case (s)
         1:       return 4'b0111;
         2:       return 4'b1101;
         3:       return 4'b1100;
         4:       return 4'b0010;
         5:       return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_state[i] = 0; m_elapsed[i] = 0; m_dur[i] = 0;
         for (int k = 0; k < 3; k++) begin m_run[i][k] = 0; m_logged[i][k] = 1'b0; end
      end
      m_faults = 0; m_vote = '0; m_emerg = 1'b0; m_weather = '0;
   endtask

   task automatic model_step(input logic [14:0] hv);
      logic [2:0] s;
      int         nxt;
      bit         v;
      int         warn_t, clear_t;
      m_emerg   = hv[12];
      m_weather = hv[14:13];
      warn_t    = m_weather[1] ? 40 : 20;
      clear_t   = (m_weather != 2'b00) ? 200 : 100;
      for (int i = 0; i < 4; i++) begin
         s = {hv[8+i], hv[4+i], hv[i]};
         v = ($countones(s) >= 2);
         m_vote[i] = v;
         for (int k = 0; k < 3; k++) begin
            if (v && !s[k]) begin
               m_run[i][k]++;
               if (m_run[i][k] == 16 && !m_logged[i][k]) begin
                  m_logged[i][k] = 1'b1;
                  if (m_faults < 255) m_faults++;
               end
            end else m_run[i][k] = 0;
            if (!v) m_logged[i][k] = 1'b0;
         end
         nxt = m_state[i];
         if (m_emerg) nxt = 5;
         else if (m_state[i] == 5) begin nxt = 3; m_dur[i] = clear_t; end
         else if (m_state[i] == 0 && v) begin nxt = 1; m_dur[i] = warn_t; end
         else if (m_state[i] == 1 && m_elapsed[i] >= m_dur[i]) nxt = 2;
         else if (m_state[i] == 2 && !v) begin nxt = 3; m_dur[i] = clear_t; end
         else if ((m_state[i] == 3 || m_state[i] == 4) && v) nxt = 2;
         else if (m_state[i] == 3 && m_elapsed[i] >= m_dur[i]) begin nxt = 4; m_dur[i] = 20; end
         else if (m_state[i] == 4 && m_elapsed[i] >= m_dur[i]) nxt = 0;
         m_elapsed[i] = (nxt != m_state[i]) ? 1 : m_elapsed[i] + 1;
         m_state[i]   = nxt;
      end
   endtask

   task automatic compare_all();
      logic [11:0] e_st;
      logic [3:0]  e_b, e_r, e_y, e_a, lp;
      int          sc;
      for (int i = 0; i < 4; i++) begin
         e_st[3*i +: 3] = 3'(m_state[i]);
         lp = lamps(m_state[i]);
         e_b[i] = lp[3]; e_r[i] = lp[2]; e_y[i] = lp[1]; e_a[i] = lp[0];
      end
      sc = 100 - 5 * m_faults;
      if (sc < 0) sc = 0;
      check("states",  32'(crossing_states_out), 32'(e_st));
      check("barrier", 32'(barrier_down), 32'(e_b));
      check("red",     32'(red_light), 32'(e_r));
      check("yellow",  32'(yellow_light), 32'(e_y));
      check("alarm",   32'(alarm_sound), 32'(e_a));
      check("debug",   32'(debug_led), 32'({(m_faults != 0), m_emerg, m_weather, m_vote}));
      check("score",   32'(efficiency_score_out), 32'(sc));
   endtask

   // Decisions at edge n see inputs driven just after edge n-3 (two sync flops + state flop).
   task automatic tick();
      @(posedge clk_50mhz);
      #1;
      h3 = h2; h2 = h1;
      h1 = {weather_mode, emergency_global, rfid_valid, vib_sensor, ir_sensor};
      if (m_active) begin
         model_step(h3);
         compare_all();
      end
   endtask

   task automatic set_train(input int c, input logic [2:0] pat);
      ir_sensor[c] = pat[0]; vib_sensor[c] = pat[1]; rfid_valid[c] = pat[2];
   endtask

   int          seg_left [4];
   logic [2:0]  seg_pat  [4];
   logic [2:0]  pat;
   int          emg_left;
   logic [2:0]  train_pats [4] = '{3'b111, 3'b011, 3'b101, 3'b110};

   initial begin
      rst_n = 1'b0; ir_sensor = '0; vib_sensor = '0; rfid_valid = '0;
      emergency_global = 1'b0; weather_mode = 2'b00;
      h1 = '0; h2 = '0; h3 = '0;
      model_reset();
      repeat (3) @(posedge clk_50mhz);
      #1;
      check("rst_states", 32'(crossing_states_out), 32'd0);
      check("rst_score",  32'(efficiency_score_out), 32'd100);
      check("rst_lamps",  32'({barrier_down, red_light, yellow_light, alarm_sound}), 32'd0);
      check("rst_debug",  32'(debug_led), 32'd0);
      rst_n = 1'b1;
      repeat (4) tick();
      m_active = 1'b1;
      repeat (100) tick();
      check("idle_states", 32'(crossing_states_out), 32'd0);
      check("idle_score",  32'(efficiency_score_out), 32'd100);

      // Full train on crossing 0.
      set_train(0, 3'b111);
      for (int k = 1; k <= 500; k++) begin
         tick();
         if (k == 2)  check("A_pre_warn", 32'(crossing_states_out[2:0]), 32'd0);
         if (k == 3)  check("A_warn",     32'(crossing_states_out[2:0]), 32'd1);
         if (k == 22) check("A_warn_end", 32'(crossing_states_out[2:0]), 32'd1);
         if (k == 23) check("A_closed",   32'(crossing_states_out[2:0]), 32'd2);
         if (k == 23) check("A_barrier",  32'(barrier_down[0]), 32'd1);
      end
      set_train(0, 3'b000);
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (k == 3)   check("A_hold",     32'(crossing_states_out[2:0]), 32'd3);
         if (k == 102) check("A_hold_end", 32'(crossing_states_out[2:0]), 32'd3);
         if (k == 103) check("A_opening",  32'(crossing_states_out[2:0]), 32'd4);
         if (k == 122) check("A_open_end", 32'(crossing_states_out[2:0]), 32'd4);
         if (k == 123) check("A_idle",     32'(crossing_states_out[2:0]), 32'd0);
      end
      check("A_score", 32'(efficiency_score_out), 32'd100);

      // Storm, crossing 2 with IR silent: one fault, doubled warn and clear.
      weather_mode = 2'b10;
      repeat (5) tick();
      set_train(2, 3'b110);
      for (int k = 1; k <= 600; k++) begin
         tick();
         if (k == 3)  check("B_warn",     32'(crossing_states_out[8:6]), 32'd1);
         if (k == 42) check("B_warn_end", 32'(crossing_states_out[8:6]), 32'd1);
         if (k == 43) check("B_closed",   32'(crossing_states_out[8:6]), 32'd2);
         if (k == 17) check("B_score_pre", 32'(efficiency_score_out), 32'd100);
         if (k == 18) check("B_score",     32'(efficiency_score_out), 32'd95);
      end
      set_train(2, 3'b000);
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (k == 3)   check("B_hold",     32'(crossing_states_out[8:6]), 32'd3);
         if (k == 202) check("B_hold_end", 32'(crossing_states_out[8:6]), 32'd3);
         if (k == 203) check("B_opening",  32'(crossing_states_out[8:6]), 32'd4);
         if (k == 223) check("B_idle",     32'(crossing_states_out[8:6]), 32'd0);
      end
      check("B_score_end", 32'(efficiency_score_out), 32'd95);
      weather_mode = 2'b00;
      repeat (5) tick();

      // Lone IR pulse: no occupancy, no fault.
      set_train(1, 3'b001);
      repeat (300) tick();
      set_train(1, 3'b000);
      repeat (10) tick();
      check("C_states", 32'(crossing_states_out), 32'd0);
      check("C_score",  32'(efficiency_score_out), 32'd95);

      // Emergency while crossing 0 is occupied and crossing 1 is opening.
      set_train(1, 3'b111);
      for (int k = 1; k <= 400; k++) begin
         tick();
         if (k == 140) check("D_c1_opening", 32'(crossing_states_out[5:3]), 32'd4);
         if (k == 143) check("D_all_emerg",  32'(crossing_states_out), 32'hB6D);
         if (k == 203) check("D_all_hold",   32'(crossing_states_out), 32'h6DB);
         if (k == 204) check("D_c0_closed",  32'(crossing_states_out[2:0]), 32'd2);
         if (k == 303) check("D_c1_opening2", 32'(crossing_states_out[5:3]), 32'd4);
         if (k == 323) check("D_c1_idle",    32'(crossing_states_out[5:3]), 32'd0);
         if (k == 30)  set_train(1, 3'b000);
         if (k == 100) set_train(0, 3'b111);
         if (k == 140) emergency_global = 1'b1;
         if (k == 200) emergency_global = 1'b0;
         if (k == 300) set_train(0, 3'b000);
      end
      repeat (100) tick();

      // Parallel trains offset by 50 cycles.
      for (int k = 1; k <= 600; k++) begin
         if (k == 1) set_train(0, 3'b111);
         tick();
         if (k == 53)  check("E_c1_warn", 32'(crossing_states_out[5:3]), 32'd1);
         if (k == 103) check("E_c2_warn", 32'(crossing_states_out[8:6]), 32'd1);
         if (k == 300) check("E_c3_idle", 32'(crossing_states_out[11:9]), 32'd0);
         if (k == 50)  set_train(1, 3'b111);
         if (k == 100) set_train(2, 3'b111);
         if (k == 200) set_train(0, 3'b000);
         if (k == 250) set_train(1, 3'b000);
         if (k == 300) set_train(2, 3'b000);
      end
      check("E_states", 32'(crossing_states_out), 32'd0);
      check("E_score",  32'(efficiency_score_out), 32'd95);

      // Randomized traffic.
      for (int i = 0; i < 4; i++) begin seg_left[i] = 0; seg_pat[i] = '0; end
      emg_left = 0;
      for (int n = 0; n < 40000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (seg_left[i] == 0) begin
               if ($urandom_range(0, 1) == 1) begin
                  seg_pat[i]  = train_pats[$urandom_range(0, 3)];
                  seg_left[i] = $urandom_range(40, 450);
               end else begin
                  seg_pat[i]  = ($urandom_range(0, 1) == 1) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
                  seg_left[i] = $urandom_range(30, 350);
               end
            end
            seg_left[i]--;
            pat = seg_pat[i];
            if ($urandom_range(0, 99) == 0) pat = pat ^ 3'(1 << $urandom_range(0, 2));
            set_train(i, pat);
         end
         if (emg_left > 0) emg_left--;
         else if ($urandom_range(0, 2999) == 0) emg_left = $urandom_range(3, 80);
         emergency_global = (emg_left > 0);
         if ($urandom_range(0, 1499) == 0) weather_mode = 2'($urandom_range(0, 3));
         tick();
      end

      // Asynchronous reset assertion mid-activity.
      m_active = 1'b0;
      @(posedge clk_50mhz);
      #5 rst_n = 1'b0;
      #1;
      check("arst_states", 32'(crossing_states_out), 32'd0);
      check("arst_score",  32'(efficiency_score_out), 32'd100);
      check("arst_lamps",  32'({barrier_down, red_light, yellow_light, alarm_sound}), 32'd0);
      check("arst_debug",  32'(debug_led), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
